// File: rtl/acondicionador_botones.sv
// Conditions four raw push-buttons: 2-FF sync, debounce and rising-edge detection per channel.
// Up/Down auto-repeat while held; holding both at once silences them until one is re-pressed.
module acondicionador_botones #(
    parameter int unsigned DEB_CYC   = 500000,
    parameter int unsigned REP_DELAY = 25000000,
    parameter int unsigned REP_RATE  = 5000000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic Clock,
    input  logic reset,
    input  logic UpIn,
    input  logic DownIn,
    input  logic TCIn,
    input  logic LpIn,
    output logic Up,
    output logic Down,
    output logic TC,
    output logic Lp
);

    localparam int unsigned NUM_CH = 4;
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REP_RATE - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    // Channel order: 0 Up, 1 Down, 2 TC, 3 Lp
    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [NUM_CH-1:0] w_stable;
    logic [NUM_CH-1:0] r_stable_d;
    logic [NUM_CH-1:0] w_rise;
    logic [1:0]        w_rep_pulse;
    logic              w_conflict;
    logic              r_tc;
    logic              r_lp;

    assign w_raw = {LpIn, TCIn, DownIn, UpIn};

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable_d <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= w_stable;
        end
    end

    for (genvar g_ch = 0; g_ch < NUM_CH; g_ch++) begin : g_deb
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;

        // The counter only runs while the synchronised input disagrees with the accepted level
        always_ff @(posedge Clock or negedge reset) begin
            if (!reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[g_ch] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_level <= r_sync2[g_ch];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_stable[g_ch] = r_level;
    end

    assign w_rise     = w_stable & ~r_stable_d;
    assign w_conflict = w_stable[0] & w_stable[1];

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_tc <= 1'b0;
            r_lp <= 1'b0;
        end else begin
            r_tc <= w_rise[2];
            r_lp <= w_rise[3];
        end
    end

    for (genvar g_rep = 0; g_rep < 2; g_rep++) begin : g_repeat
        rep_state_e       r_state;
        rep_state_e       w_state_next;
        logic [CNT_W-1:0] r_timer;
        logic [CNT_W-1:0] w_timer_next;
        logic             w_expired;
        logic             w_pulse;
        logic             r_pulse;

        assign w_expired = (r_timer == '0);

        always_ff @(posedge Clock or negedge reset) begin
            if (!reset) begin
                r_state <= StIdle;
                r_timer <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_timer <= w_timer_next;
                r_pulse <= w_pulse;
            end
        end

        // Release is tested before expiry so a release on the expiry cycle never pulses
        always_comb begin
            w_state_next = r_state;
            w_timer_next = r_timer;
            if (w_conflict) begin
                w_state_next = StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_rise[g_rep]) begin
                            w_state_next = StDelay;
                            w_timer_next = DELAY_LOAD;
                        end
                    end
                    StDelay: begin
                        if (!w_stable[g_rep]) begin
                            w_state_next = StIdle;
                        end else if (w_expired) begin
                            w_state_next = StRepeat;
                            w_timer_next = RATE_LOAD;
                        end else begin
                            w_timer_next = r_timer - CNT_W'(1);
                        end
                    end
                    StRepeat: begin
                        if (!w_stable[g_rep]) begin
                            w_state_next = StIdle;
                        end else if (w_expired) begin
                            w_timer_next = RATE_LOAD;
                        end else begin
                            w_timer_next = r_timer - CNT_W'(1);
                        end
                    end
                    default: w_state_next = StIdle;
                endcase
            end
        end

        always_comb begin
            w_pulse = 1'b0;
            if (!w_conflict) begin
                case (r_state)
                    StIdle:   w_pulse = w_rise[g_rep];
                    StDelay:  w_pulse = w_stable[g_rep] & w_expired;
                    StRepeat: w_pulse = w_stable[g_rep] & w_expired;
                    default:  w_pulse = 1'b0;
                endcase
            end
        end

        assign w_rep_pulse[g_rep] = r_pulse;
    end

    assign Up   = w_rep_pulse[0];
    assign Down = w_rep_pulse[1];
    assign TC   = r_tc;
    assign Lp   = r_lp;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: segment-based stimulus, pulse predictions queued per cycle,
// compared by an independent monitor on the falling clock edge.
module tb_acondicionador_botones;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RD   = 10;
    localparam int unsigned RR   = 3;
    localparam int          MAXL = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic up_in = 1'b0, down_in = 1'b0, tc_in = 1'b0, lp_in = 1'b0;
    logic up, down, tc, lp;

    acondicionador_botones #(
        .DEB_CYC  (DEB),
        .REP_DELAY(RD),
        .REP_RATE (RR),
        .CNT_W    (25)
    ) dut (
        .Clock (clk),
        .reset (rst_n),
        .UpIn  (up_in),
        .DownIn(down_in),
        .TCIn  (tc_in),
        .LpIn  (lp_in),
        .Up    (up),
        .Down  (down),
        .TC    (tc),
        .Lp    (lp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         ecount = 0;
    bit         mon_en = 1'b0;
    int         seg_len = 0;
    logic [3:0] stim [1:MAXL];  // bit0 Up, bit1 Down, bit2 TC, bit3 Lp
    bit         st   [0:3][0:MAXL];
    logic [3:0] em   [1:MAXL];
    logic [3:0] mon_got;
    logic [3:0] mon_want;

    // Edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_got  = {lp, tc, down, up};
            mon_want = 4'b0000;
            while (exp_q.size() > 0 && exp_q[0].cyc < ecount) begin
                checks++;
                failures++;
                $display("FAIL missed_pulse cyc=%0d expected mask=%b never seen",
                         exp_q[0].cyc, exp_q[0].mask);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == ecount) begin
                mon_want = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            checks++;
            if (mon_got !== mon_want) begin
                failures++;
                $display("FAIL pulses cyc=%0d got {Lp,TC,Down,Up}=%b expected=%b",
                         ecount, mon_got, mon_want);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic new_seg(input int len);
        seg_len = len;
        for (int c = 1; c <= MAXL; c++) stim[c] = 4'b0000;
    endtask

    task automatic hold(input int ch, input int from, input int to);
        for (int c = from; c <= to; c++) stim[c][ch] = 1'b1;
    endtask

    function automatic bit smp(input int ch, input int c);
        if (c < 1 || c > seg_len) return 1'b0;
        return stim[c][ch];
    endfunction

    function automatic bit conf(input int k);
        return st[0][k] && st[1][k];
    endfunction

    // Reference: a level is accepted once DEB consecutive samples (2 cycles old) disagree with it;
    // a pulse follows one cycle after acceptance, then repeats at +RD, +RR... while held alone.
    task automatic build_expect();
        exp_t e;
        bit   agree;
        bit   ok;
        int   k, t, upto;
        for (int ch = 0; ch < 4; ch++) begin
            st[ch][0] = 1'b0;
            for (int kk = 1; kk <= seg_len; kk++) begin
                st[ch][kk] = st[ch][kk-1];
                agree = 1'b1;
                for (int j = 0; j < int'(DEB); j++)
                    if (smp(ch, kk - 2 - j) == st[ch][kk-1]) agree = 1'b0;
                if (agree) st[ch][kk] = ~st[ch][kk-1];
            end
        end
        for (int c = 1; c <= seg_len; c++) em[c] = 4'b0000;
        for (int ch = 2; ch < 4; ch++)
            for (int kk = 2; kk <= seg_len; kk++)
                if (st[ch][kk-1] && !st[ch][kk-2]) em[kk][ch] = 1'b1;
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 1; r < seg_len; r++) begin
                if (st[ch][r] && !st[ch][r-1] && !conf(r)) begin
                    k = r + 1;
                    em[k][ch] = 1'b1;
                    t = k + int'(RD);
                    upto = k;
                    ok = 1'b1;
                    while (t <= seg_len && ok) begin
                        for (int j = upto; j < t; j++)
                            if (!st[ch][j] || conf(j)) ok = 1'b0;
                        upto = t;
                        if (ok) em[t][ch] = 1'b1;
                        t = t + int'(RR);
                    end
                end
            end
        end
        for (int c = 1; c <= seg_len; c++) begin
            if (em[c] != 4'b0000) begin
                e.cyc  = c;
                e.mask = em[c];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic apply(input int c);
        {lp_in, tc_in, down_in, up_in} = stim[c];
    endtask

    // Releases reset, plays the segment, then asserts reset right after its last cycle is checked
    task automatic run_segment();
        build_expect();
        @(negedge clk);
        #1;
        apply(1);
        rst_n = 1'b1;
        for (int c = 2; c <= seg_len; c++) begin
            @(negedge clk);
            #1;
            apply(c);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lp, tc, down, up} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_clear got {Lp,TC,Down,Up}=%b expected=0000", {lp, tc, down, up});
        end
        exp_q.delete();
    endtask

    task automatic rand_seg(input int len);
        int  c;
        int  run;
        bit  lvl;
        new_seg(len);
        for (int ch = 0; ch < 4; ch++) begin
            c = 1;
            lvl = 1'($urandom_range(0, 1));
            while (c <= seg_len) begin
                if ($urandom_range(0, 3) == 0) run = int'($urandom_range(1, DEB));
                else                           run = int'($urandom_range(DEB, 35));
                for (int i = 0; i < run && c <= seg_len; i++) begin
                    stim[c][ch] = lvl;
                    c++;
                end
                lvl = ~lvl;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        new_seg(50);                                   run_segment();  // idle
        new_seg(40); hold(2, 1, 20);                   run_segment();  // TC press
        new_seg(30); hold(0, 1, 3); hold(0, 5, 7);     run_segment();  // glitches
        new_seg(50); hold(0, 1, 30);                   run_segment();  // Up repeat
        new_seg(30); hold(0, 1, 13);                   run_segment();  // release on expiry
        new_seg(90); hold(0, 1, 60); hold(1, 1, 25); hold(0, 70, 75);
        run_segment();                                                 // Up+Down conflict
        new_seg(23); hold(1, 1, 23);                   run_segment();  // reset on Down pulse
        new_seg(40); hold(1, 1, 30);                   run_segment();  // held through reset

        for (int s = 0; s < 8; s++) begin
            rand_seg(160);
            run_segment();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
